// File: rtl/reset_seq.sv
// Power-on / soft reset sequencer: synchronises board reset release, then
// releases the clock-divider reset followed later by the core reset.
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_HOLD    = 4,
  parameter int CORE_HOLD   = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  output logic       rst_div,
  output logic       rst_core,
  output logic       ready,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    HOLD_DIV  = 2'd1,
    HOLD_CORE = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_HOLD - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rel;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_div_q, rst_core_q, ready_q;

  // Deassertion synchroniser: assertion is asynchronous, release walks a 1 in.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rel = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ASSERT: begin
        if (rel) begin
          state_d = HOLD_DIV;
          cnt_d   = '0;
        end
      end
      HOLD_DIV: begin
        if (cnt_q == DIV_LAST) begin
          state_d = HOLD_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD_CORE: begin
        // A request during the hold restarts it, so release tracks the last one.
        if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (soft_rst_req) begin
          state_d = HOLD_CORE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      rst_div_q  <= 1'b1;
      rst_core_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_div_q  <= (state_d == ASSERT) || (state_d == HOLD_DIV);
      rst_core_q <= (state_d != RUN);
      ready_q    <= (state_d == RUN);
    end
  end

  assign rst_div   = rst_div_q;
  assign rst_core  = rst_core_q;
  assign ready     = ready_q;
  assign seq_state = state_q;

endmodule
